// File: rtl/region_blitter.sv
// region_blitter: draws up to NUM_SLOTS rectangular ROM images into a VGA
// write port, in ascending slot order, each at its own top row.
//
// Ports:
//   clock, resetn      clock and synchronous active-low reset
//   start              begin a pass (sampled only while idle)
//   slot_mask          slots to draw, sampled with start
//   slot_y             per-slot top row, slot i at [i*Y_W +: Y_W]
//   rom_addr/rom_slot  registered ROM pixel index and image select
//   rom_data           ROM colour, valid ROM_LAT cycles after rom_addr
//   busy, done         busy outside IDLE; done pulses for one cycle at end
//   writeEn,x,y,colour registered VGA pixel write
//
// Build option: define REGION_BLITTER_TRANSPARENT_EN to suppress writes of
// pixels whose colour equals KEY_COLOUR.
module region_blitter #(
  parameter int NUM_SLOTS  = 4,
  parameter int REGION_W   = 320,
  parameter int REGION_H   = 50,
  parameter int SCREEN_H   = 240,
  parameter int COLOUR_W   = 3,
  parameter int ADDR_W     = 14,
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int ROM_LAT    = 1,
  parameter int KEY_COLOUR = 0
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [NUM_SLOTS-1:0]     slot_mask,
  input  logic [NUM_SLOTS*Y_W-1:0] slot_y,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic [2:0]               rom_slot,
  input  logic [COLOUR_W-1:0]      rom_data,
  output logic                     busy,
  output logic                     done,
  output logic                     writeEn,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COLOUR_W-1:0]      colour
);

  localparam int CW = (REGION_W > 1) ? $clog2(REGION_W) : 1;
  localparam int RW = (REGION_H > 1) ? $clog2(REGION_H) : 1;
  localparam int DW = $clog2(ROM_LAT + 1) + 1;
  localparam logic [COLOUR_W-1:0] KEY = COLOUR_W'(KEY_COLOUR);
`ifdef REGION_BLITTER_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_SEEK, S_DRAW, S_DRAIN, S_DONE} state_t;

  state_t                   state, state_n;
  logic [NUM_SLOTS-1:0]     mask;
  logic [NUM_SLOTS*Y_W-1:0] sy;
  logic [3:0]               cur_slot;
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic [Y_W-1:0]           cur_y;
  logic                     drew;
  logic [DW-1:0]            drain_cnt;

  // lowest enabled slot at or above cur_slot (descending scan, last hit wins)
  logic           seek_found;
  logic [2:0]     seek_idx;
  logic [Y_W-1:0] seek_y;

  always_comb begin
    seek_found = 1'b0;
    seek_idx   = '0;
    seek_y     = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= cur_slot)) begin
        seek_found = 1'b1;
        seek_idx   = 3'(i);
        seek_y     = sy[i*Y_W +: Y_W];
      end
    end
  end

  logic last_col, last_px;
  assign last_col = (col == CW'(REGION_W - 1));
  assign last_px  = last_col && (row == RW'(REGION_H - 1));

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_SEEK;
      S_SEEK: begin
        if (seek_found) state_n = S_DRAW;
        else if (drew)  state_n = S_DRAIN;
        else            state_n = S_DONE;
      end
      S_DRAW:  if (last_px) state_n = S_SEEK;
      S_DRAIN: if (drain_cnt == DW'(ROM_LAT)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // sequencing datapath: slot latch, pixel counters, ROM address
  always_ff @(posedge clock) begin
    if (!resetn) begin
      mask      <= '0;
      sy        <= '0;
      cur_slot  <= '0;
      col       <= '0;
      row       <= '0;
      cur_y     <= '0;
      drew      <= 1'b0;
      drain_cnt <= '0;
      rom_addr  <= '0;
      rom_slot  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mask     <= slot_mask;
          sy       <= slot_y;
          cur_slot <= '0;
          drew     <= 1'b0;
        end
        S_SEEK: begin
          drain_cnt <= '0;
          if (seek_found) begin
            col      <= '0;
            row      <= '0;
            rom_addr <= '0;
            rom_slot <= seek_idx;
            cur_y    <= seek_y;
          end
        end
        S_DRAW: begin
          if (last_px) begin
            for (int i = 0; i < NUM_SLOTS; i++)
              if (rom_slot == 3'(i)) mask[i] <= 1'b0;
            cur_slot <= {1'b0, rom_slot} + 4'd1;
            drew     <= 1'b1;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            if (last_col) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + DW'(1);
        default: ;
      endcase
    end
  end

  // issue-side tags for the address currently on rom_addr; clipping is
  // decided on the untruncated row so wrapped y never reaches the screen
  logic [31:0]    y_full;
  logic           iss_vld;
  logic [X_W-1:0] iss_x;
  logic [Y_W-1:0] iss_y;

  assign y_full  = 32'(cur_y) + 32'(row);
  assign iss_vld = (state == S_DRAW) && (y_full < 32'(SCREEN_H));
  assign iss_x   = X_W'(col);
  assign iss_y   = Y_W'(y_full);

  // tag delay matching ROM latency; stage ROM_LAT-1 lines up with rom_data
  logic [ROM_LAT-1:0]          vld_pipe;
  logic [ROM_LAT-1:0][X_W-1:0] x_pipe;
  logic [ROM_LAT-1:0][Y_W-1:0] y_pipe;
  logic                        key_hit;

  assign key_hit = TRANSP && (rom_data == KEY);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_pipe <= '0;
      x_pipe   <= '0;
      y_pipe   <= '0;
      writeEn  <= 1'b0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
    end else begin
      vld_pipe[0] <= iss_vld;
      x_pipe[0]   <= iss_x;
      y_pipe[0]   <= iss_y;
      for (int k = 1; k < ROM_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        x_pipe[k]   <= x_pipe[k-1];
        y_pipe[k]   <= y_pipe[k-1];
      end
      writeEn <= vld_pipe[ROM_LAT-1] && !key_hit;
      x       <= x_pipe[ROM_LAT-1];
      y       <= y_pipe[ROM_LAT-1];
      colour  <= rom_data;
    end
  end

endmodule

// File: tb/tb_region_blitter.sv
// Directed bench for region_blitter: two instances (ROM latency 1 and 2)
// with small 4x2 images, bench ROMs, a write monitor and a pixel model.
module tb_region_blitter;

  localparam int W = 4, H = 2, SH = 240;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [3:0]  slot_mask = '0;
  logic [31:0] slot_y = '0;

  logic [3:0] rom_addr1, rom_addr2;
  logic [2:0] rom_slot1, rom_slot2;
  logic [2:0] rom_data1, rom_data2, r2a;
  logic       busy1, busy2, done1, done2, we1, we2;
  logic [8:0] x1, x2;
  logic [7:0] y1, y2;
  logic [2:0] c1, c2;

  always #5 clock = ~clock;

  region_blitter #(.NUM_SLOTS(4), .REGION_W(W), .REGION_H(H), .SCREEN_H(SH),
    .COLOUR_W(3), .ADDR_W(4), .X_W(9), .Y_W(8), .ROM_LAT(1), .KEY_COLOUR(0))
  u_dut1 (.clock(clock), .resetn(resetn), .start(start1), .slot_mask(slot_mask),
    .slot_y(slot_y), .rom_addr(rom_addr1), .rom_slot(rom_slot1), .rom_data(rom_data1),
    .busy(busy1), .done(done1), .writeEn(we1), .x(x1), .y(y1), .colour(c1));

  region_blitter #(.NUM_SLOTS(4), .REGION_W(W), .REGION_H(H), .SCREEN_H(SH),
    .COLOUR_W(3), .ADDR_W(4), .X_W(9), .Y_W(8), .ROM_LAT(2), .KEY_COLOUR(0))
  u_dut2 (.clock(clock), .resetn(resetn), .start(start2), .slot_mask(slot_mask),
    .slot_y(slot_y), .rom_addr(rom_addr2), .rom_slot(rom_slot2), .rom_data(rom_data2),
    .busy(busy2), .done(done2), .writeEn(we2), .x(x2), .y(y2), .colour(c2));

  // ROM 1 (1 cycle): addr[2:0]^3, so only addr 3 reads colour 0.
  // ROM 2 (2 cycles): addr[2:0].
  always @(posedge clock) begin
    rom_data1 <= rom_addr1[2:0] ^ 3'd3;
    r2a       <= rom_addr2[2:0];
    rom_data2 <= r2a;
  end

  int q1[$], q2[$];
  int bc[3] = '{0, 0, 0};
  int dc[3] = '{0, 0, 0};

  always @(negedge clock) begin
    if (we1) q1.push_back(int'({x1, y1, c1}));
    if (we2) q2.push_back(int'({x2, y2, c2}));
    if (busy1) bc[1]++;
    if (busy2) bc[2]++;
    if (done1) dc[1]++;
    if (done2) dc[2]++;
  end

`ifdef REGION_BLITTER_TRANSPARENT_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int qsize(input int d);
    return (d == 1) ? q1.size() : q2.size();
  endfunction

  function automatic int qget(input int d, input int i);
    return (d == 1) ? q1[i] : q2[i];
  endfunction

  task automatic setstart(input int d, input logic v);
    if (d == 1) start1 = v;
    else        start2 = v;
  endtask

  // one pass on dut d; optional re-pulse of start 'repulse' cycles in;
  // compares writes against the pixel model, pass length and done count
  task automatic run_pass(input string tag, input int d, input logic [3:0] m,
                          input logic [31:0] ys, input int repulse, output int base);
    int bb, db, lat, exp_busy, nexp;
    int exp_q[$];
    bit seen;
    slot_mask = m;
    slot_y    = ys;
    base = qsize(d);
    bb   = bc[d];
    db   = dc[d];
    setstart(d, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      setstart(d, (i == repulse));
      if ((d == 1) ? done1 : done2) seen = 1'b1;
    end
    setstart(d, 1'b0);
    chk({tag, " done seen"}, int'(seen), 1);
    repeat (3) @(negedge clock);

    lat = (d == 1) ? 1 : 2;
    exp_busy = 2;
    for (int s = 0; s < 4; s++) begin
      if (!m[s]) continue;
      exp_busy += 1 + W * H;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          int a, yv, col;
          a   = r * W + c;
          yv  = int'(ys[s*8 +: 8]) + r;
          col = (d == 1) ? ((a & 7) ^ 3) : (a & 7);
          if (yv >= SH) continue;
          if (TRANSP && col == 0) continue;
          exp_q.push_back(int'({9'(c), 8'(yv), 3'(col)}));
        end
    end
    if (m != 0) exp_busy += lat + 1;

    nexp = exp_q.size();
    chk({tag, " write count"}, qsize(d) - base, nexp);
    for (int i = 0; i < nexp && base + i < qsize(d); i++)
      chk({tag, " pixel"}, qget(d, base + i), exp_q[i]);
    chk({tag, " busy cycles"}, bc[d] - bb, exp_busy);
    chk({tag, " done pulses"}, dc[d] - db, 1);
    chk({tag, " busy after"}, int'((d == 1) ? busy1 : busy2), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, hits;
    repeat (3) @(negedge clock);
    chk("reset writeEn", int'(we1), 0);
    chk("reset busy", int'(busy1), 0);
    chk("reset done", int'(done1), 0);
    chk("reset rom_addr", int'(rom_addr1), 0);
    chk("reset xyc", int'({x1, y1, c1}), 0);
    chk("reset dut2 busy/we", int'({busy2, we2}), 0);
    resetn = 1'b1;
    @(negedge clock);

    // two slots in ascending order, one done pulse; key pixel (3,10)
    run_pass("t1", 1, 4'b0101, {8'd0, 8'd100, 8'd0, 8'd10}, -1, b);
    hits = 0;
    for (int i = b; i < q1.size(); i++)
      if (q1[i][19:11] == 9'd3 && q1[i][10:3] == 8'd10) hits++;
    chk("t6 key pixel writes", hits, TRANSP ? 0 : 1);
    chk("t1 rom_slot last", int'(rom_slot1), 2);

    // empty mask: SEEK then DONE, no writes
    b = q1.size();
    slot_mask = 4'b0000;
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    chk("t2 seek busy/done", int'({busy1, done1}), 2'b10);
    @(negedge clock);
    chk("t2 done busy/done", int'({busy1, done1}), 2'b11);
    @(negedge clock);
    chk("t2 idle busy/done", int'({busy1, done1}), 2'b00);
    repeat (3) @(negedge clock);
    chk("t2 writes", q1.size() - b, 0);

    // bottom clipping: y=240 row suppressed, pass length unchanged
    run_pass("t3", 1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd239}, -1, b);

    // ROM latency 2: colour tracks address
    run_pass("t4", 2, 4'b0110, {8'd0, 8'd30, 8'd5, 8'd0}, -1, b);
    chk("t4 rom_slot last", int'(rom_slot2), 2);

    // start re-pulsed during DRAW is ignored
    run_pass("t5 repulse", 1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd20}, 4, b);

    // reset mid-DRAW, then a clean pass from address 0
    slot_mask = 4'b0001;
    slot_y    = {8'd0, 8'd0, 8'd0, 8'd20};
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    repeat (5) @(negedge clock);
    chk("t5 mid busy", int'(busy1), 1);
    resetn = 1'b0;
    @(negedge clock);
    chk("t5 reset we/busy/done", int'({we1, busy1, done1}), 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("t5 reset no write", int'(we1), 0);
    run_pass("t5 redraw", 1, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd20}, -1, b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/region_blitter.md
Name: region_blitter

Overview:
Generalised successor to the fixed four-line text painter. It sequences up to NUM_SLOTS rectangular ROM images into the VGA write port, one after another, each at a per-slot vertical offset. Pixel coordinates come from row/column counters; there is no modulo or divide. Pipeline delay compensates for ROM read latency. It sits between game control (start/slot_mask) and the VGA adapter (x, y, colour, writeEn).

Parameters:
NUM_SLOTS, 4, number of image slots (1..8)
REGION_W, 320, image width in pixels
REGION_H, 50, image height in pixels
SCREEN_H, 240, rows at or beyond this are clipped (no write)
COLOUR_W, 3, colour bits
ADDR_W, 14, ROM address width; must satisfy 2^ADDR_W >= REGION_W*REGION_H
X_W, 9, x width
Y_W, 8, y width
ROM_LAT, 1, cycles from rom_addr to valid rom_data (1..3)
KEY_COLOUR, 0, transparent colour (used only with the optional feature)

Ports:
clock  in  1  system clock
resetn  in  1  synchronous, active-low reset
start  in  1  request a draw pass; sampled only in IDLE
slot_mask  in  NUM_SLOTS  bit i=1 draws slot i; sampled with start
slot_y  in  NUM_SLOTS*Y_W  top row of slot i at bits [i*Y_W +: Y_W]; sampled with start
rom_addr  out  ADDR_W  pixel index into the current slot's image (registered)
rom_slot  out  3  index of the slot whose ROM is selected (registered)
rom_data  in  COLOUR_W  ROM output, valid ROM_LAT cycles after rom_addr
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the pass completes
writeEn  out  1  pixel write strobe (registered)
x  out  X_W  pixel column (registered)
y  out  Y_W  pixel row (registered)
colour  out  COLOUR_W  pixel colour (registered)

Behaviour:
- Reset: state IDLE; all outputs 0; counters, mask and offsets cleared; delay pipeline flushed (no stale writeEn after reset).
- States:
  - IDLE: start=1 latches slot_mask and slot_y, sets cur_slot=0, goes to SEEK.
  - SEEK (1 cycle): selects the lowest enabled slot >= cur_slot. If one exists, loads col=row=0, sets rom_slot, goes to DRAW. If none exists and at least one slot was drawn, goes to DRAIN. If none exists and the mask is empty, goes straight to DONE.
  - DRAW (REGION_W*REGION_H cycles): each cycle issues rom_addr = row*REGION_W + col, kept as a running counter.
    - col increments; on col = REGION_W-1 it wraps to 0 and row increments.
    - After the last pixel, clears the mask bit, sets cur_slot = slot+1 and returns to SEEK. This gives one bubble cycle between slots.
  - DRAIN (ROM_LAT+1 cycles): flushes the pipeline, then goes to DONE.
  - DONE (1 cycle): done=1, busy=1; then IDLE.
- Pipeline:
  - The valid, x=col and y=slot_y[slot]+row tags are delayed ROM_LAT cycles alongside the ROM access.
  - The output registers capture the tags together with rom_data. x, y, colour and writeEn are therefore valid ROM_LAT+1 cycles after the matching rom_addr, and colour always corresponds to the same pixel as x/y.
- Arithmetic: y addition is truncated to Y_W bits. A pixel whose untruncated y >= SCREEN_H gets writeEn=0 (clipped), but its cycle is still consumed.
- writeEn is 0 in IDLE, SEEK bubbles, and whenever the delayed valid tag is 0.
- start while busy: ignored; no queuing. slot_mask/slot_y changes during a pass have no effect.
- Reset mid-pass: the next edge gives IDLE, writeEn=0, busy=0, done=0. A later start begins from address 0.
- Slots are always drawn in ascending index order; each enabled slot is drawn exactly once per pass.

Optional Feature:
Macro: REGION_BLITTER_TRANSPARENT_EN.
- When defined: an output pixel whose rom_data == KEY_COLOUR has writeEn=0, so the background is preserved. Timing and pixel count are unchanged.
- When undefined: KEY_COLOUR is ignored and every in-screen pixel is written.

Test Plan:
1. REGION_W=4, REGION_H=2, ROM_LAT=1, mask=4'b0101, slot_y0=10, slot_y2=100 -> 16 writes in order:
   - slot 0: (0..3,10) then (0..3,11);
   - slot 2: (0..3,100) then (0..3,101);
   - then exactly one done pulse, busy low afterwards.
2. mask=0, start pulse -> zero writes; done=1 in the 2nd cycle after start is sampled; busy high for exactly 2 cycles.
3. slot_y0=239, REGION_H=2, mask=4'b0001 -> 4 writes at y=239; row y=240 is clipped (writeEn=0); the pass length is unchanged.
4. ROM_LAT=2, with a bench ROM returning rom_addr[2:0] -> every write has colour == (y-slot_y)*REGION_W+x mod 8.
5. start re-pulsed mid-DRAW -> ignored, write count unchanged. resetn=0 mid-DRAW -> writeEn=0 and busy=0 next cycle. A new start then re-draws from rom_addr=0.
6. With REGION_BLITTER_TRANSPARENT_EN defined and KEY_COLOUR=0, ROM returns 0 at addr 3 -> no write at (3,slot_y), all others written. Without the macro -> (3,slot_y) is written with colour 0.
